// File: rtl/iic_pkg.sv
// Shared types and constants for the HMC588L I2C register responder.
package iic_pkg;

  localparam logic [6:0] SLAVE_ADDR    = 7'h1E;
  localparam logic [7:0] DEVICE_WRADDR = {SLAVE_ADDR, 1'b0};
  localparam logic [7:0] DEVICE_RDADDR = {SLAVE_ADDR, 1'b1};

  // clk cycles per half SCL period at 100 kHz with a 100 MHz clk
  localparam int unsigned SCL_HALF = 500;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StReg,
    StRegAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } iic_state_e;

endpackage

// File: rtl/iic_line_sync.sv
// Two-flop synchronizers for scl/sda plus SCL edge and START/STOP detection.
module iic_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [1:0] synchronize, [2] holds the previous synchronized value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  always_comb begin
    sda_o      = sda_q[1];
    scl_rise_o = scl_q[1] & ~scl_q[2];
    scl_fall_o = ~scl_q[1] & scl_q[2];
    start_o    = ~sda_q[1] & sda_q[2] & scl_q[1] & scl_q[2];
    stop_o     = sda_q[1] & ~sda_q[2] & scl_q[1] & scl_q[2];
  end

endmodule

// File: rtl/iic_slave_regs.sv
// I2C register-bank responder (address 7'h1E). Define IIC_SLAVE_AUTOINC_EN to
// advance reg_addr after each register write and each ACKed read byte.
module iic_slave_regs
  import iic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       iic_done
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_line_sync u_line_sync (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  iic_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_phase_q, ack_phase_d;
  logic       rw_q, rw_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic       reg_wr_q, reg_wr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_rd_q, reg_rd_d;
  logic       busy_q, busy_d;
  logic       iic_done_q, iic_done_d;
  logic [7:0] rx_byte;
  logic       rx_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      sda_low_q   <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wr_q    <= 1'b0;
      reg_wdata_q <= 8'h00;
      reg_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      iic_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_phase_q <= ack_phase_d;
      rw_q        <= rw_d;
      sda_low_q   <= sda_low_d;
      reg_addr_q  <= reg_addr_d;
      reg_wr_q    <= reg_wr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_rd_q    <= reg_rd_d;
      busy_q      <= busy_d;
      iic_done_q  <= iic_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_phase_d = ack_phase_q;
    rw_d        = rw_q;
    sda_low_d   = sda_low_q;
    reg_addr_d  = reg_addr_q;
    reg_wr_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;
    reg_rd_d    = 1'b0;
    busy_d      = busy_q;
    iic_done_d  = 1'b0;
    rx_byte     = {shift_q[6:0], sda_s};
    rx_done     = scl_rise && (bit_cnt_q == 3'd0);

`ifdef IIC_SLAVE_AUTOINC_EN
    if (reg_wr_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end
`endif

    if (stop_det) begin
      state_d     = StIdle;
      sda_low_d   = 1'b0;
      ack_phase_d = 1'b0;
      busy_d      = 1'b0;
      iic_done_d  = busy_q;
    end else if (start_det) begin
      state_d     = StAddr;
      bit_cnt_d   = 3'd7;
      sda_low_d   = 1'b0;
      ack_phase_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StReg, StWdata: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
          if (rx_done) begin
            if (state_q == StAddr) begin
              if (rx_byte == DEVICE_WRADDR || rx_byte == DEVICE_RDADDR) begin
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
                state_d = StAddrAck;
              end else begin
                state_d = StIgnore;
              end
            end else if (state_q == StReg) begin
              reg_addr_d = rx_byte;
              state_d    = StRegAck;
            end else begin
              reg_wr_d    = 1'b1;
              reg_wdata_d = rx_byte;
              state_d     = StWdataAck;
            end
          end
        end
        // First falling edge starts driving ACK, the second one ends it.
        StAddrAck, StRegAck, StWdataAck: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_low_d   = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_low_d   = 1'b0;
              ack_phase_d = 1'b0;
              bit_cnt_d   = 3'd7;
              if (state_q == StAddrAck && rw_q) begin
                reg_rd_d = 1'b1;
                state_d  = StRdata;
              end else if (state_q == StAddrAck) begin
                state_d = StReg;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (reg_rd_q) begin
            shift_d   = reg_rdata;
            sda_low_d = ~reg_rdata[7];
            bit_cnt_d = 3'd7;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_low_d   = 1'b0;
              ack_phase_d = 1'b0;
              state_d     = StRdataAck;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = StIgnore;
            end else begin
              ack_phase_d = 1'b1;
`ifdef IIC_SLAVE_AUTOINC_EN
              reg_addr_d = reg_addr_q + 8'd1;
`endif
            end
          end else if (scl_fall && ack_phase_q) begin
            ack_phase_d = 1'b0;
            reg_rd_d    = 1'b1;
            state_d     = StRdata;
          end
        end
        StIdle, StIgnore: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wr    = reg_wr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_rd    = reg_rd_q;
  assign busy      = busy_q;
  assign iic_done  = iic_done_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bus-level bench for iic_slave_regs: a timed I2C master plus write/read scoreboards.
module tb_iic_slave_regs;
  import iic_pkg::*;

  localparam int H = SCL_HALF / 10;
`ifdef IIC_SLAVE_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda_low;
  wire        sda;
  logic [7:0] reg_addr;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       iic_done;
  logic       rdata_by_addr;
  logic [7:0] rdata_fixed;

  int compared;
  int mismatched;
  int done_cnt;
  int drive_cnt;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign reg_rdata = rdata_by_addr ? (reg_addr ^ 8'hC3) : rdata_fixed;

  iic_slave_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (m_scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .iic_done  (iic_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard side: register strobes are popped against expectations.
  always @(negedge clk) begin
    logic [15:0] exp_wr;
    logic [7:0]  exp_rd;
    if (rst_n) begin
      if (iic_done) done_cnt = done_cnt + 1;
      if (sda === 1'b0 && !m_sda_low) drive_cnt = drive_cnt + 1;
      if (reg_wr) begin
        compared = compared + 1;
        if (wr_q.size() == 0) begin
          mismatched = mismatched + 1;
          $display("FAIL wr_unexpected: got addr %h data %h, expected no write",
                   reg_addr, reg_wdata);
        end else begin
          exp_wr = wr_q.pop_front();
          if ({reg_addr, reg_wdata} !== exp_wr) begin
            mismatched = mismatched + 1;
            $display("FAIL wr_event: got addr %h data %h, expected addr %h data %h",
                     reg_addr, reg_wdata, exp_wr[15:8], exp_wr[7:0]);
          end
        end
      end
      if (reg_rd) begin
        compared = compared + 1;
        if (rd_q.size() == 0) begin
          mismatched = mismatched + 1;
          $display("FAIL rd_unexpected: got addr %h, expected no read", reg_addr);
        end else begin
          exp_rd = rd_q.pop_front();
          if (reg_addr !== exp_rd) begin
            mismatched = mismatched + 1;
            $display("FAIL rd_event: got addr %h, expected addr %h", reg_addr, exp_rd);
          end
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_clks(H / 2);
    m_sda_low = 1'b0;
    wait_clks(H / 2);
    m_scl = 1'b1;
    wait_clks(H / 2);
    m_sda_low = 1'b1;
    wait_clks(H / 2);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(H / 2);
    m_sda_low = 1'b1;
    wait_clks(H / 2);
    m_scl = 1'b1;
    wait_clks(H / 2);
    m_sda_low = 1'b0;
    wait_clks(H);
  endtask

  task automatic send_bit(input logic b);
    wait_clks(H / 2);
    m_sda_low = ~b;
    wait_clks(H / 2);
    m_scl = 1'b1;
    wait_clks(H);
    m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clks(H / 2);
    m_sda_low = 1'b0;
    wait_clks(H / 2);
    m_scl = 1'b1;
    wait_clks(H / 2);
    ack = sda;
    wait_clks(H / 2);
    m_scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    m_sda_low = 1'b0;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(H);
      m_scl = 1'b1;
      wait_clks(H / 2);
      d[i] = sda;
      wait_clks(H / 2);
      m_scl = 1'b0;
    end
    wait_clks(H / 2);
    m_sda_low = ~nack;
    wait_clks(H / 2);
    m_scl = 1'b1;
    wait_clks(H);
    m_scl = 1'b0;
    wait_clks(1);
    m_sda_low = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(5);
    compared = compared + 1;
    if (sda !== 1'b1 || reg_addr !== 8'h00 || reg_wr !== 1'b0 || reg_wdata !== 8'h00 ||
        reg_rd !== 1'b0 || busy !== 1'b0 || iic_done !== 1'b0) begin
      mismatched = mismatched + 1;
      $display("FAIL reset_values: got sda %b addr %h wr %b wdata %h rd %b busy %b done %b, %s",
               sda, reg_addr, reg_wr, reg_wdata, reg_rd, busy, iic_done,
               "expected sda 1 and all outputs 0");
    end
    rst_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int d0;
    d0 = done_cnt;
    wr_q.push_back({8'h05, 8'hA5});
    i2c_start();
    write_byte(DEVICE_WRADDR, a0);
    write_byte(8'h05, a1);
    write_byte(8'hA5, a2);
    compared = compared + 1;
    if ({a0, a1, a2} !== 3'b000) begin
      mismatched = mismatched + 1;
      $display("FAIL write_acks: got %b, expected 000", {a0, a1, a2});
    end
    compared = compared + 1;
    if (busy !== 1'b1) begin
      mismatched = mismatched + 1;
      $display("FAIL write_busy: got %b, expected 1", busy);
    end
    i2c_stop();
    compared = compared + 1;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      mismatched = mismatched + 1;
      $display("FAIL write_done: got %0d pulses busy %b, expected 1 pulse busy 0",
               done_cnt - d0, busy);
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d;
    int d0;
    d0 = done_cnt;
    rdata_by_addr = 1'b0;
    rdata_fixed = 8'h5A;
    rd_q.push_back(8'h05);
    i2c_start();
    write_byte(DEVICE_WRADDR, a0);
    write_byte(8'h05, a1);
    i2c_start();
    write_byte(DEVICE_RDADDR, a2);
    read_byte(1'b1, d);
    i2c_stop();
    compared = compared + 1;
    if ({a0, a1, a2} !== 3'b000) begin
      mismatched = mismatched + 1;
      $display("FAIL read_acks: got %b, expected 000", {a0, a1, a2});
    end
    compared = compared + 1;
    if (d !== 8'h5A) begin
      mismatched = mismatched + 1;
      $display("FAIL read_data: got %h, expected 5a", d);
    end
    compared = compared + 1;
    if (reg_addr !== 8'h05 || done_cnt - d0 != 1) begin
      mismatched = mismatched + 1;
      $display("FAIL read_end: got addr %h pulses %0d, expected addr 05 pulses 1",
               reg_addr, done_cnt - d0);
    end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    logic busy_mid;
    int d0;
    d0 = done_cnt;
    drive_cnt = 0;
    i2c_start();
    write_byte(8'h40, a0);
    write_byte(8'h05, a1);
    busy_mid = busy;
    i2c_stop();
    compared = compared + 1;
    if ({a0, a1} !== 2'b11 || drive_cnt != 0) begin
      mismatched = mismatched + 1;
      $display("FAIL mismatch_sda: got acks %b drive cycles %0d, expected 11 and 0",
               {a0, a1}, drive_cnt);
    end
    compared = compared + 1;
    if (busy_mid !== 1'b0 || done_cnt != d0) begin
      mismatched = mismatched + 1;
      $display("FAIL mismatch_busy: got busy %b pulses %0d, expected 0 and 0",
               busy_mid, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2;
    int d0;
    i2c_start();
    write_byte(DEVICE_WRADDR, a0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_clks(H / 2);
    m_sda_low = 1'b0;
    wait_clks(H / 2);
    m_scl = 1'b1;
    wait_clks(H / 2);
    compared = compared + 1;
    if (busy !== 1'b1 || a0 !== 1'b0) begin
      mismatched = mismatched + 1;
      $display("FAIL midreset_pre: got busy %b ack %b, expected 1 and 0", busy, a0);
    end
    rst_n = 1'b0;
    wait_clks(1);
    compared = compared + 1;
    if (sda !== 1'b1 || busy !== 1'b0 || reg_addr !== 8'h00) begin
      mismatched = mismatched + 1;
      $display("FAIL midreset_post: got sda %b busy %b addr %h, expected 1 0 00",
               sda, busy, reg_addr);
    end
    wait_clks(H / 2);
    m_scl = 1'b0;
    wait_clks(5);
    rst_n = 1'b1;
    i2c_stop();
    d0 = done_cnt;
    wr_q.push_back({8'h07, 8'hC3});
    i2c_start();
    write_byte(DEVICE_WRADDR, a0);
    write_byte(8'h07, a1);
    write_byte(8'hC3, a2);
    i2c_stop();
    compared = compared + 1;
    if ({a0, a1, a2} !== 3'b000 || done_cnt - d0 != 1) begin
      mismatched = mismatched + 1;
      $display("FAIL midreset_write: got acks %b pulses %0d, expected 000 and 1",
               {a0, a1, a2}, done_cnt - d0);
    end
  endtask

  task automatic test_burst_write();
    logic a0, a1, a2, a3, a4;
    wr_q.push_back({8'hFE, 8'h11});
    wr_q.push_back({AutoInc ? 8'hFF : 8'hFE, 8'h22});
    wr_q.push_back({AutoInc ? 8'h00 : 8'hFE, 8'h33});
    i2c_start();
    write_byte(DEVICE_WRADDR, a0);
    write_byte(8'hFE, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    write_byte(8'h33, a4);
    i2c_stop();
    compared = compared + 1;
    if ({a0, a1, a2, a3, a4} !== 5'b00000) begin
      mismatched = mismatched + 1;
      $display("FAIL burst_acks: got %b, expected 00000", {a0, a1, a2, a3, a4});
    end
  endtask

  task automatic test_start_mid_wdata();
    logic a0, a1, a2, a3, a4;
    int d0;
    d0 = done_cnt;
    wr_q.push_back({8'h09, 8'h77});
    i2c_start();
    write_byte(DEVICE_WRADDR, a0);
    write_byte(8'h05, a1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_start();
    write_byte(DEVICE_WRADDR, a2);
    write_byte(8'h09, a3);
    write_byte(8'h77, a4);
    i2c_stop();
    compared = compared + 1;
    if ({a0, a1, a2, a3, a4} !== 5'b00000 || done_cnt - d0 != 1) begin
      mismatched = mismatched + 1;
      $display("FAIL start_mid_wdata: got acks %b pulses %0d, expected 00000 and 1",
               {a0, a1, a2, a3, a4}, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    logic [7:0] second_addr;
    second_addr = AutoInc ? 8'h11 : 8'h10;
    rdata_by_addr = 1'b1;
    rd_q.push_back(8'h10);
    rd_q.push_back(second_addr);
    i2c_start();
    write_byte(DEVICE_WRADDR, a0);
    write_byte(8'h10, a1);
    i2c_start();
    write_byte(DEVICE_RDADDR, a2);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop();
    compared = compared + 1;
    if ({a0, a1, a2} !== 3'b000 || d0 !== (8'h10 ^ 8'hC3)) begin
      mismatched = mismatched + 1;
      $display("FAIL b2b_read0: got acks %b data %h, expected 000 and %h",
               {a0, a1, a2}, d0, 8'h10 ^ 8'hC3);
    end
    compared = compared + 1;
    if (d1 !== (second_addr ^ 8'hC3)) begin
      mismatched = mismatched + 1;
      $display("FAIL b2b_read1: got %h, expected %h", d1, second_addr ^ 8'hC3);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    done_cnt = 0;
    drive_cnt = 0;
    rst_n = 1'b0;
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    rdata_by_addr = 1'b0;
    rdata_fixed = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_reset_mid();
    test_burst_write();
    test_start_mid_wdata();
    test_back_to_back_read();
    wait_clks(20);
    compared = compared + 1;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      mismatched = mismatched + 1;
      $display("FAIL leftover_events: got %0d writes %0d reads pending, expected 0 and 0",
               wr_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
